// File: rtl/fifo_control_pkg.sv
// fifo_control_pkg: shared FIFO sizing constants and default flag thresholds
package fifo_control_pkg;
    localparam int BITNUMBER   = 6;
    localparam int ADDR_WIDTH  = 4;
    localparam int LENGTH      = 2 ** ADDR_WIDTH;
    localparam int COUNT_WIDTH = ADDR_WIDTH + 1;
    localparam int AF_THRESH   = 12;
    localparam int AE_THRESH   = 3;
endpackage

// File: rtl/fifo_control_if.sv
// fifo_control_if: push/pop requests, storage strobes/addresses and status flags
interface fifo_control_if
    import fifo_control_pkg::*;
#(
    parameter int AW = ADDR_WIDTH
) ();
    logic          push;
    logic          pop;
    logic          write;
    logic          read;
    logic [AW-1:0] ptr_write;
    logic [AW-1:0] ptr_read;
    logic [AW:0]   fifo_count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    modport slave (
        input  push, pop,
        output write, read, ptr_write, ptr_read, fifo_count,
        output full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport master (
        output push, pop,
        input  write, read, ptr_write, ptr_read, fifo_count,
        input  full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_ptr_counter.sv
// fifo_ptr_counter: wrapping storage address pointer that advances when enabled
module fifo_ptr_counter
    import fifo_control_pkg::*;
#(
    parameter int WIDTH = ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] ptr
);
    // Advance by one per accepted access; wrap comes from natural rollover
    always_ff @(posedge clk or posedge reset)
        if (reset) ptr <= '0;
        else if (en) ptr <= ptr + 1'b1;
endmodule

// File: rtl/fifo_control.sv
// fifo_control: pointer, occupancy and status-flag authority for the FIFO storage array
module fifo_control
    import fifo_control_pkg::*;
#(
    parameter int ADDR_WIDTH = fifo_control_pkg::ADDR_WIDTH,
    parameter int LENGTH     = fifo_control_pkg::LENGTH,
    parameter int AF_THRESH  = fifo_control_pkg::AF_THRESH,
    parameter int AE_THRESH  = fifo_control_pkg::AE_THRESH
) (
    input logic            clk,
    input logic            reset,
    fifo_control_if.slave  bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LEN_C = CW'(LENGTH);
    localparam logic [CW-1:0] AF_C  = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C  = CW'(AE_THRESH);

    logic          wr_ok;
    logic          rd_ok;
    logic [CW-1:0] count;
    logic          ovf;
    logic          unf;

    // Flags come from the registered count only; accept decisions use those flags.
    // A full FIFO still takes a push paired with a pop; an empty one never takes a pop.
    always_comb begin
        bus.full         = count == LEN_C;
        bus.empty        = count == '0;
        bus.almost_full  = count >= AF_C;
        bus.almost_empty = count <= AE_C;
        wr_ok            = bus.push & (~bus.full | bus.pop);
        rd_ok            = bus.pop & ~bus.empty;
        bus.write        = wr_ok;
        bus.read         = rd_ok;
        bus.fifo_count   = count;
        bus.overflow     = ovf;
        bus.underflow    = unf;
    end

    fifo_ptr_counter #(.WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (wr_ok),
        .ptr   (bus.ptr_write)
    );

    fifo_ptr_counter #(.WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (rd_ok),
        .ptr   (bus.ptr_read)
    );

    // Occupancy moves only when exactly one side is accepted; error flags are sticky
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= (wr_ok & ~rd_ok) ? count + 1'b1 :
                     (rd_ok & ~wr_ok) ? count - 1'b1 : count;
            ovf   <= ovf | (bus.push & ~wr_ok);
            unf   <= unf | (bus.pop & ~rd_ok);
        end
endmodule

// File: tb/tb_fifo_control.sv
// tb_fifo_control: table-driven directed check of fifo_control plus async-reset sequence
module tb_fifo_control;
    import fifo_control_pkg::*;

    typedef struct packed {
        logic       write;
        logic       read;
        logic [3:0] pw;
        logic [3:0] pr;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
    } obs_t;

    typedef struct packed {
        logic push;
        logic pop;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vq[$];

    fifo_control_if bus ();

    fifo_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic push, pop, w, r, input int pw, pr, cnt,
                                input logic f, e, af, ae, ov, un);
        vec_t v;
        v.push = push;
        v.pop = pop;
        v.exp.write = w;
        v.exp.read = r;
        v.exp.pw = 4'(pw);
        v.exp.pr = 4'(pr);
        v.exp.cnt = 5'(cnt);
        v.exp.full = f;
        v.exp.empty = e;
        v.exp.af = af;
        v.exp.ae = ae;
        v.exp.ovf = ov;
        v.exp.unf = un;
        return v;
    endfunction

    function automatic obs_t snap();
        obs_t o;
        o.write = bus.write;
        o.read = bus.read;
        o.pw = bus.ptr_write;
        o.pr = bus.ptr_read;
        o.cnt = bus.fifo_count;
        o.full = bus.full;
        o.empty = bus.empty;
        o.af = bus.almost_full;
        o.ae = bus.almost_empty;
        o.ovf = bus.overflow;
        o.unf = bus.underflow;
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %p want %p", name, got, exp);
        end
    endtask

    // Strobes sampled before the edge, registered state sampled after it
    task automatic apply(input string name, input vec_t v);
        obs_t got;
        logic w, r;
        @(negedge clk);
        bus.push = v.push;
        bus.pop = v.pop;
        #1;
        w = bus.write;
        r = bus.read;
        @(posedge clk);
        #1;
        got = snap();
        got.write = w;
        got.read = r;
        check(name, got, v.exp);
    endtask

    initial begin
        bus.push = 1'b0;
        bus.pop = 1'b0;

        // reset idle
        for (int i = 0; i < 5; i++) vq.push_back(mk(0,0, 0,0, 0,0, 0, 0,1,0,1, 0,0));
        // 16 pushes
        vq.push_back(mk(1,0, 1,0,  1,0,  1, 0,0,0,1, 0,0));
        vq.push_back(mk(1,0, 1,0,  2,0,  2, 0,0,0,1, 0,0));
        vq.push_back(mk(1,0, 1,0,  3,0,  3, 0,0,0,1, 0,0));
        vq.push_back(mk(1,0, 1,0,  4,0,  4, 0,0,0,0, 0,0));
        vq.push_back(mk(1,0, 1,0,  5,0,  5, 0,0,0,0, 0,0));
        vq.push_back(mk(1,0, 1,0,  6,0,  6, 0,0,0,0, 0,0));
        vq.push_back(mk(1,0, 1,0,  7,0,  7, 0,0,0,0, 0,0));
        vq.push_back(mk(1,0, 1,0,  8,0,  8, 0,0,0,0, 0,0));
        vq.push_back(mk(1,0, 1,0,  9,0,  9, 0,0,0,0, 0,0));
        vq.push_back(mk(1,0, 1,0, 10,0, 10, 0,0,0,0, 0,0));
        vq.push_back(mk(1,0, 1,0, 11,0, 11, 0,0,0,0, 0,0));
        vq.push_back(mk(1,0, 1,0, 12,0, 12, 0,0,1,0, 0,0));
        vq.push_back(mk(1,0, 1,0, 13,0, 13, 0,0,1,0, 0,0));
        vq.push_back(mk(1,0, 1,0, 14,0, 14, 0,0,1,0, 0,0));
        vq.push_back(mk(1,0, 1,0, 15,0, 15, 0,0,1,0, 0,0));
        vq.push_back(mk(1,0, 1,0,  0,0, 16, 1,0,1,0, 0,0));
        // full: push+pop accepted, then lone pushes rejected
        vq.push_back(mk(1,1, 1,1,  1,1, 16, 1,0,1,0, 0,0));
        vq.push_back(mk(1,0, 0,0,  1,1, 16, 1,0,1,0, 1,0));
        vq.push_back(mk(1,0, 0,0,  1,1, 16, 1,0,1,0, 1,0));
        // drain 16
        vq.push_back(mk(0,1, 0,1,  1,2, 15, 0,0,1,0, 1,0));
        vq.push_back(mk(0,1, 0,1,  1,3, 14, 0,0,1,0, 1,0));
        vq.push_back(mk(0,1, 0,1,  1,4, 13, 0,0,1,0, 1,0));
        vq.push_back(mk(0,1, 0,1,  1,5, 12, 0,0,1,0, 1,0));
        vq.push_back(mk(0,1, 0,1,  1,6, 11, 0,0,0,0, 1,0));
        vq.push_back(mk(0,1, 0,1,  1,7, 10, 0,0,0,0, 1,0));
        vq.push_back(mk(0,1, 0,1,  1,8,  9, 0,0,0,0, 1,0));
        vq.push_back(mk(0,1, 0,1,  1,9,  8, 0,0,0,0, 1,0));
        vq.push_back(mk(0,1, 0,1,  1,10, 7, 0,0,0,0, 1,0));
        vq.push_back(mk(0,1, 0,1,  1,11, 6, 0,0,0,0, 1,0));
        vq.push_back(mk(0,1, 0,1,  1,12, 5, 0,0,0,0, 1,0));
        vq.push_back(mk(0,1, 0,1,  1,13, 4, 0,0,0,0, 1,0));
        vq.push_back(mk(0,1, 0,1,  1,14, 3, 0,0,0,1, 1,0));
        vq.push_back(mk(0,1, 0,1,  1,15, 2, 0,0,0,1, 1,0));
        vq.push_back(mk(0,1, 0,1,  1,0,  1, 0,0,0,1, 1,0));
        vq.push_back(mk(0,1, 0,1,  1,1,  0, 0,1,0,1, 1,0));
        // extra pop, then push+pop on empty
        vq.push_back(mk(0,1, 0,0,  1,1,  0, 0,1,0,1, 1,1));
        vq.push_back(mk(1,1, 1,0,  2,1,  1, 0,0,0,1, 1,1));
        vq.push_back(mk(0,1, 0,1,  2,2,  0, 0,1,0,1, 1,1));
        vq.push_back(mk(1,0, 1,0,  3,2,  1, 0,0,0,1, 1,1));
        vq.push_back(mk(1,1, 1,1,  4,3,  1, 0,0,0,1, 1,1));
        vq.push_back(mk(0,0, 0,0,  4,3,  1, 0,0,0,1, 1,1));

        repeat (2) @(posedge clk);
        #1 check("in_reset", snap(), mk(0,0, 0,0, 0,0, 0, 0,1,0,1, 0,0).exp);
        @(negedge clk);
        reset = 1'b0;

        foreach (vq[i]) apply($sformatf("vec%0d", i), vq[i]);

        // fill to 7 with overflow still set, then reset between edges
        apply("fill2", mk(1,0, 1,0,  5,3, 2, 0,0,0,1, 1,1));
        apply("fill3", mk(1,0, 1,0,  6,3, 3, 0,0,0,1, 1,1));
        apply("fill4", mk(1,0, 1,0,  7,3, 4, 0,0,0,0, 1,1));
        apply("fill5", mk(1,0, 1,0,  8,3, 5, 0,0,0,0, 1,1));
        apply("fill6", mk(1,0, 1,0,  9,3, 6, 0,0,0,0, 1,1));
        apply("fill7", mk(1,0, 1,0, 10,3, 7, 0,0,0,0, 1,1));
        @(negedge clk);
        bus.push = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check("async_reset", snap(), mk(0,0, 0,0, 0,0, 0, 0,1,0,1, 0,0).exp);
        @(negedge clk);
        reset = 1'b0;
        bus.push = 1'b1;
        #1 check("post_reset_pre", snap(), mk(0,0, 1,0, 0,0, 0, 0,1,0,1, 0,0).exp);
        @(posedge clk);
        #1 check("post_reset_post", snap(), mk(0,0, 1,0, 1,0, 1, 0,0,0,1, 0,0).exp);
        @(negedge clk);
        bus.push = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
